// File: rtl/proc_pkg.sv
// Definitions shared by the fetch/PC datapath and the multicycle controller:
// PC source encodings, the NOP word, instruction field positions and fetch FSM states.
package proc_pkg;
  localparam logic [1:0]  PCSRC_ALU    = 2'b00;
  localparam logic [1:0]  PCSRC_ALUOUT = 2'b10;
  localparam logic [15:0] NOP_INSTR    = 16'h0000;

  localparam int OPCODE_HI = 15;
  localparam int OPCODE_LO = 12;
  localparam int FUNC_HI   = 3;
  localparam int FUNC_LO   = 0;

  typedef enum logic {
    F_IDLE = 1'b0,
    F_WAIT = 1'b1
  } fetch_state_e;
endpackage

// File: rtl/pc_next_logic.sv
// Combinational PC write-enable resolution and next-PC source mux.
// The reserved PCSrc codes select the current PC, so a write leaves the PC unchanged.
module pc_next_logic #(
  parameter int DATA_W = 16
) (
  input  logic [1:0]        i_pc_src,
  input  logic              i_pc_write,
  input  logic              i_beq_cond,
  input  logic              i_bnq_cond,
  input  logic              i_alu_zero,
  input  logic [DATA_W-1:0] i_alu_result,
  input  logic [DATA_W-1:0] i_alu_out_q,
  input  logic [DATA_W-1:0] i_pc,
  output logic              o_pc_we,
  output logic [DATA_W-1:0] o_pc_next
);
  import proc_pkg::*;

  always_comb begin
    // Both condition bits set makes the branch always taken.
    o_pc_we = i_pc_write | (i_beq_cond & i_alu_zero) | (i_bnq_cond & ~i_alu_zero);
    case (i_pc_src)
      PCSRC_ALU:    o_pc_next = i_alu_result;
      PCSRC_ALUOUT: o_pc_next = i_alu_out_q;
      default:      o_pc_next = i_pc;
    endcase
  end
endmodule

// File: rtl/fetch_pc_unit.sv
// PC and instruction register owner: fetches over a valid handshake, stalls the
// controller while a fetch is outstanding and forces a NOP on fetch timeout.
module fetch_pc_unit #(
  parameter int                DATA_W   = 16,
  parameter logic [DATA_W-1:0] PC_RESET = 16'h0000,
  parameter int                TIMEOUT  = 15,
  parameter int                TO_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        PCSrc,
  input  logic              PCWrite,
  input  logic              PCBEqCond,
  input  logic              PCBNqCond,
  input  logic              IRWrite,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] alu_out_q,
  input  logic              alu_zero,
  output logic [DATA_W-1:0] imem_addr,
  output logic              imem_req,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              imem_valid,
  output logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] ir,
  output logic [3:0]        opcode,
  output logic [3:0]        func_field,
  output logic              fetch_stall,
  output logic              fetch_err,
  output logic              o_dbg_state
);
  import proc_pkg::*;

  // Handshake: imem_req asks for the word at imem_addr; the word is taken in the
  // cycle imem_valid is high while a fetch is in flight, otherwise it is ignored.
  fetch_state_e      r_state, w_state_next;
  logic [TO_W-1:0]   r_count, w_count_next;
  logic [DATA_W-1:0] r_pc, r_ir;
  logic              r_err;
  logic              w_imem_req;
  logic              w_timeout_hit;
  logic              w_fetch_done;
  logic              w_pc_we;
  logic              w_pc_load;
  logic [DATA_W-1:0] w_pc_next;

  pc_next_logic #(.DATA_W(DATA_W)) u_pc_next (
    .i_pc_src     (PCSrc),
    .i_pc_write   (PCWrite),
    .i_beq_cond   (PCBEqCond),
    .i_bnq_cond   (PCBNqCond),
    .i_alu_zero   (alu_zero),
    .i_alu_result (alu_result),
    .i_alu_out_q  (alu_out_q),
    .i_pc         (r_pc),
    .o_pc_we      (w_pc_we),
    .o_pc_next    (w_pc_next)
  );

  assign w_timeout_hit = (r_state == F_WAIT) && (r_count == TO_W'(TIMEOUT)) && !imem_valid;
  assign w_fetch_done  = ((r_state == F_IDLE) && IRWrite && imem_valid) ||
                         ((r_state == F_WAIT) && (imem_valid || w_timeout_hit));
  // During a fetch the PC write is held back until the instruction arrives.
  assign w_pc_load     = w_pc_we && (!IRWrite || w_fetch_done);

  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_imem_req   = 1'b0;
    case (r_state)
      F_IDLE: begin
        w_imem_req = IRWrite;
        if (IRWrite && !imem_valid) begin
          w_state_next = F_WAIT;
          w_count_next = TO_W'(1);
        end
      end
      F_WAIT: begin
        w_imem_req = 1'b1;
        if (imem_valid || w_timeout_hit) begin
          w_state_next = F_IDLE;
          w_count_next = '0;
        end else begin
          w_count_next = r_count + TO_W'(1);
        end
      end
      default: begin
        w_state_next = F_IDLE;
        w_count_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= F_IDLE;
      r_count <= '0;
      r_pc    <= PC_RESET;
      r_ir    <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      if (w_pc_load)     r_pc  <= w_pc_next;
      if (w_fetch_done)  r_ir  <= w_timeout_hit ? DATA_W'(NOP_INSTR) : imem_rdata;
      if (w_timeout_hit) r_err <= 1'b1;
    end
  end

  assign imem_addr   = r_pc;
  assign imem_req    = w_imem_req;
  assign pc          = r_pc;
  assign ir          = r_ir;
  assign opcode      = r_ir[OPCODE_HI:OPCODE_LO];
  assign func_field  = r_ir[FUNC_HI:FUNC_LO];
  assign fetch_stall = IRWrite & ~imem_valid & ~w_timeout_hit;
  assign fetch_err   = r_err;
  assign o_dbg_state = r_state;
endmodule
